gpio_irq_ctrl: RTL and testbench

Second-generation memory-mapped GPIO controller on the Simple_Mem bus. It has a parametrised pin count, an input synchroniser, and atomic set/clear/toggle output registers. It adds per-pin rising/falling edge interrupt detection with a W1C status register and a single aggregated interrupt line. It sits behind the bus fabric, and pin pads with tristate buffers are instantiated at the top level.

---
 rtl/gpio_irq_ctrl_if.sv | 23 ++
 rtl/gpio_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_ctrl_if.sv
// Simple_Mem bus bundle between the fabric (master) and the GPIO controller (slave).
interface gpio_irq_ctrl_if;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [3:0]  wr_byteEn;
  logic        wr_ready;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [3:0]  rd_byteEn;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output wr_addr, wr_valid, wr_data, wr_byteEn, rd_addr, rd_valid, rd_byteEn,
    input  wr_ready, rd_ready, rd_data
  );

  modport slave (
    input  wr_addr, wr_valid, wr_data, wr_byteEn, rd_addr, rd_valid, rd_byteEn,
    output wr_ready, rd_ready, rd_data
  );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO with atomic output ops and W1C edge interrupts; bus ready/rd_data one cycle after accept.
// A channel whose ready is high cannot accept, so held valid yields one access per two cycles.
module gpio_irq_ctrl #(
  parameter int          PINS        = 32,
  parameter logic [31:0] ADDR        = 32'h1000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  gpio_irq_ctrl_if.slave  bus,
  input  logic [PINS-1:0] pins_in,
  output logic [PINS-1:0] pins_out,
  output logic [PINS-1:0] pins_oe,
  output logic            irq
);

  localparam int ARM_CYC = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_CYC + 1);

  logic [PINS-1:0] dir_q, dir_d, out_q, out_d;
  logic [PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [PINS-1:0] status_q, status_d, prev_q, prev_d;
  logic [PINS-1:0] sync_q [SYNC_STAGES];
  logic [PINS-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]   arm_cnt_q, arm_cnt_d;
  logic            wr_ready_q, wr_ready_d, rd_ready_q, rd_ready_d, irq_q, irq_d;
  logic [31:0]     rd_data_q, rd_data_d;

  logic            wr_acc, rd_acc, armed;
  logic [31:0]     wbm, rbm, wdat32, rd_word;
  logic [PINS-1:0] wbits, wbmp, w1c, in_sync, rise, fall;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt_q == CW'(ARM_CYC));
  assign wr_acc  = bus.wr_valid && (bus.wr_addr[31:6] == ADDR[31:6]) && !wr_ready_q;
  assign rd_acc  = bus.rd_valid && (bus.rd_addr[31:6] == ADDR[31:6]) && !rd_ready_q;

  always_comb begin
    sync_d[0] = pins_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d    = in_sync;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);
    // Edges are masked until the synchroniser has flushed its reset zeros.
    rise = armed ? (in_sync & ~prev_q & rise_en_q) : '0;
    fall = armed ? (~in_sync & prev_q & fall_en_q) : '0;
  end

  always_comb begin
    wbm       = {{8{bus.wr_byteEn[3]}}, {8{bus.wr_byteEn[2]}},
                 {8{bus.wr_byteEn[1]}}, {8{bus.wr_byteEn[0]}}};
    wdat32    = bus.wr_data & wbm;
    wbits     = wdat32[PINS-1:0];
    wbmp      = wbm[PINS-1:0];
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_acc) begin
      case (bus.wr_addr[5:2])
        4'h0:    dir_d     = (dir_q & ~wbmp) | wbits;
        4'h2:    out_d     = (out_q & ~wbmp) | wbits;
        4'h3:    out_d     = out_q | wbits;
        4'h4:    out_d     = out_q & ~wbits;
        4'h5:    out_d     = out_q ^ wbits;
        4'h6:    rise_en_d = (rise_en_q & ~wbmp) | wbits;
        4'h7:    fall_en_d = (fall_en_q & ~wbmp) | wbits;
        4'h8:    w1c       = wbits;
        default: ;
      endcase
    end
    // A fresh edge outranks a simultaneous W1C of the same bit.
    status_d   = (status_q & ~w1c) | rise | fall;
    irq_d      = |status_d;
    wr_ready_d = wr_acc;
  end

  always_comb begin
    rbm     = {{8{bus.rd_byteEn[3]}}, {8{bus.rd_byteEn[2]}},
               {8{bus.rd_byteEn[1]}}, {8{bus.rd_byteEn[0]}}};
    rd_word = '0;
    case (bus.rd_addr[5:2])
      4'h0:    rd_word[PINS-1:0] = dir_q;
      4'h1:    rd_word[PINS-1:0] = in_sync;
      4'h2:    rd_word[PINS-1:0] = out_q;
      4'h6:    rd_word[PINS-1:0] = rise_en_q;
      4'h7:    rd_word[PINS-1:0] = fall_en_q;
      4'h8:    rd_word[PINS-1:0] = status_q;
      default: rd_word = '0;
    endcase
    rd_ready_d = rd_acc;
    rd_data_d  = rd_acc ? (rd_word & rbm) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q      <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      prev_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      arm_cnt_q  <= '0;
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      prev_q     <= prev_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      arm_cnt_q  <= arm_cnt_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_ready = rd_ready_q;
  assign bus.rd_data  = rd_data_q;
  assign pins_out     = out_q;
  assign pins_oe      = dir_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl; read expectations go through a scoreboard queue.
module tb_gpio_irq_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SS   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pins_in;
  logic [31:0] pins_out, pins_oe;
  logic        irq;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rdq[$];
  int          acc_cnt;

  gpio_irq_ctrl_if bus_if ();

  gpio_irq_ctrl #(.PINS(32), .ADDR(BASE), .SYNC_STAGES(SS)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .pins_oe  (pins_oe),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] exp);
    logic [31:0] e;
    rdq.push_back(exp);
    bus_if.rd_addr   = addr;
    bus_if.rd_byteEn = be;
    bus_if.rd_valid  = 1'b1;
    tick();
    bus_if.rd_valid = 1'b0;
    chk({tag, "_rdy"}, {31'd0, bus_if.rd_ready}, 32'd1);
    e = rdq.pop_front();
    chk(tag, bus_if.rd_data, e);
    tick();
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    bus_if.wr_addr   = addr;
    bus_if.wr_data   = data;
    bus_if.wr_byteEn = be;
    bus_if.wr_valid  = 1'b1;
    tick();
    bus_if.wr_valid = 1'b0;
    chk({tag, "_wrdy"}, {31'd0, bus_if.wr_ready}, 32'd1);
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    pins_in          = '1;
    bus_if.wr_addr   = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.wr_data   = '0;
    bus_if.wr_byteEn = '0;
    bus_if.rd_addr   = '0;
    bus_if.rd_valid  = 1'b0;
    bus_if.rd_byteEn = '0;
    repeat (3) tick();
    chk("rst_irq",      {31'd0, irq}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus_if.wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, bus_if.rd_ready}, 32'd0);
    chk("rst_rd_data",  bus_if.rd_data, 32'd0);
    chk("rst_pins_out", pins_out, 32'd0);
    chk("rst_pins_oe",  pins_oe, 32'd0);
    reset = 1'b0;

    // Pins held high across reset must not fire once armed.
    repeat (6) tick();
    chk("arm_irq", {31'd0, irq}, 32'd0);
    do_read("rd_status0", BASE + 32'h20, 4'hF, 32'd0);
    do_read("rd_dir0",    BASE + 32'h00, 4'hF, 32'd0);
    do_read("rd_out0",    BASE + 32'h08, 4'hF, 32'd0);
    do_read("rd_in_ones", BASE + 32'h04, 4'hF, 32'hFFFF_FFFF);
    pins_in = '0;
    repeat (4) tick();
    do_read("rd_in_zero", BASE + 32'h04, 4'hF, 32'd0);

    // Atomic output operations.
    do_write("w_out", BASE + 32'h08, 32'h0000_00F0, 4'hF);
    do_write("w_set", BASE + 32'h0C, 32'h0000_000F, 4'hF);
    do_write("w_clr", BASE + 32'h10, 32'h0000_0030, 4'hF);
    do_write("w_tgl", BASE + 32'h14, 32'h0000_0101, 4'hF);
    do_read("rd_out_ops", BASE + 32'h08, 4'hF, 32'h0000_01CE);
    chk("pins_out_ops", pins_out, 32'h0000_01CE);
    do_read("rd_out_be1", BASE + 32'h08, 4'b0001, 32'h0000_00CE);
    do_read("rd_set_wo",  BASE + 32'h0C, 4'hF, 32'd0);
    do_write("w_dir_be", BASE + 32'h00, 32'hFFFF_FFFF, 4'b0011);
    do_read("rd_dir_be", BASE + 32'h00, 4'hF, 32'h0000_FFFF);
    chk("pins_oe_be", pins_oe, 32'h0000_FFFF);

    // Rising edge on pin 0: irq exactly SS+1 cycles after the pin change.
    do_write("w_rise_en", BASE + 32'h18, 32'h1, 4'hF);
    pins_in[0] = 1'b1;
    repeat (SS) tick();
    chk("irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, irq}, 32'd1);
    do_read("rd_status_rise", BASE + 32'h20, 4'hF, 32'h1);
    do_write("w1c_bit0", BASE + 32'h20, 32'h1, 4'hF);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    do_read("rd_status_clr", BASE + 32'h20, 4'hF, 32'd0);

    // Falling edge on pin 2 coinciding with a W1C of bit 2.
    do_write("w_fall_en", BASE + 32'h1C, 32'h4, 4'hF);
    pins_in[2] = 1'b1;
    repeat (4) tick();
    chk("irq_no_rise2", {31'd0, irq}, 32'd0);
    pins_in[2] = 1'b0;
    repeat (SS) tick();
    bus_if.wr_addr   = BASE + 32'h20;
    bus_if.wr_data   = 32'h4;
    bus_if.wr_byteEn = 4'hF;
    bus_if.wr_valid  = 1'b1;
    tick();
    bus_if.wr_valid = 1'b0;
    chk("w1c_race_wrdy", {31'd0, bus_if.wr_ready}, 32'd1);
    chk("irq_race", {31'd0, irq}, 32'd1);
    tick();
    do_read("rd_status_race", BASE + 32'h20, 4'hF, 32'h4);
    do_write("w_fall_dis", BASE + 32'h1C, 32'h0, 4'hF);
    do_read("rd_status_keep", BASE + 32'h20, 4'hF, 32'h4);
    do_write("w1c_bit2", BASE + 32'h20, 32'h4, 4'hF);
    do_read("rd_status_clr2", BASE + 32'h20, 4'hF, 32'd0);

    // Held wr_valid on TGL: ready alternates, two toggles cancel.
    acc_cnt          = 0;
    bus_if.wr_addr   = BASE + 32'h14;
    bus_if.wr_data   = 32'h1;
    bus_if.wr_byteEn = 4'hF;
    bus_if.wr_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("held_rdy", {31'd0, bus_if.wr_ready}, 32'(i % 2));
      acc_cnt += int'(bus_if.wr_ready);
      tick();
    end
    bus_if.wr_valid = 1'b0;
    chk("held_accepts", 32'(acc_cnt), 32'd2);
    tick();
    do_read("rd_out_held", BASE + 32'h08, 4'hF, 32'h0000_01CE);

    // Same-cycle read and write of OUT: read sees the old value.
    rdq.push_back(32'h0000_01CE);
    bus_if.rd_addr   = BASE + 32'h08;
    bus_if.rd_byteEn = 4'hF;
    bus_if.rd_valid  = 1'b1;
    bus_if.wr_addr   = BASE + 32'h08;
    bus_if.wr_data   = 32'h0000_00A5;
    bus_if.wr_valid  = 1'b1;
    tick();
    bus_if.rd_valid = 1'b0;
    bus_if.wr_valid = 1'b0;
    chk("simul_wrdy", {31'd0, bus_if.wr_ready}, 32'd1);
    chk("simul_rrdy", {31'd0, bus_if.rd_ready}, 32'd1);
    chk("simul_rdata", bus_if.rd_data, rdq.pop_front());
    tick();
    do_read("rd_out_new", BASE + 32'h08, 4'hF, 32'h0000_00A5);
    do_read("rd_in_pin0", BASE + 32'h04, 4'hF, 32'h1);
    do_read("rd_unmap24", BASE + 32'h24, 4'hF, 32'd0);
    do_read("rd_unmap3c", BASE + 32'h3C, 4'hF, 32'd0);
    do_write("w_unmap3c", BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);

    // Out-of-window accesses: no ready, no effect.
    bus_if.wr_addr  = BASE + 32'h48;
    bus_if.wr_data  = 32'h0;
    bus_if.wr_valid = 1'b1;
    bus_if.rd_addr  = BASE + 32'h48;
    bus_if.rd_valid = 1'b1;
    tick();
    chk("oow_wrdy1", {31'd0, bus_if.wr_ready}, 32'd0);
    chk("oow_rrdy1", {31'd0, bus_if.rd_ready}, 32'd0);
    tick();
    chk("oow_wrdy2", {31'd0, bus_if.wr_ready}, 32'd0);
    bus_if.wr_valid = 1'b0;
    bus_if.rd_valid = 1'b0;
    tick();
    do_read("rd_out_oow", BASE + 32'h08, 4'hF, 32'h0000_00A5);
    chk("pins_out_oow", pins_out, 32'h0000_00A5);

    // Reset in the accept cycle: no ready, no update.
    bus_if.wr_addr  = BASE + 32'h08;
    bus_if.wr_data  = 32'h0000_00FF;
    bus_if.wr_valid = 1'b1;
    reset           = 1'b1;
    tick();
    chk("rst_mid_wrdy", {31'd0, bus_if.wr_ready}, 32'd0);
    chk("rst_mid_out", pins_out, 32'd0);
    bus_if.wr_valid = 1'b0;
    reset           = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
